// File: rtl/obi_pkg.sv
// ---------------------------------------------------------------------------
// obi_pkg
// Shared types for the OBI burst master:
//   obi_state_e : burst controller states (IDLE -> ISSUE -> DRAIN -> DONE)
//   obi_req_t   : fields carried by one OBI request (addr, we, be, wdata)
//   OUTST_W     : width of the outstanding-transaction counter (max 3)
//   OBI_BE_FULL : byte enables for a full 32-bit word
// ---------------------------------------------------------------------------
package obi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } obi_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    localparam int         OUTST_W     = 2;
    localparam logic [3:0] OBI_BE_FULL = 4'hF;

endpackage

// File: rtl/obi_burst_master_if.sv
// ---------------------------------------------------------------------------
// obi_burst_master_if
// OBI bus bundle between the burst master and a memory-side responder.
//   req/addr/we/be/wdata : request channel, driven by the master
//   gnt                  : request accepted, driven by the responder
//   rvalid/err/rdata     : response channel, driven by the responder
// ---------------------------------------------------------------------------
interface obi_burst_master_if;

    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, err, rdata
    );

endinterface

// File: rtl/obi_burst_master.sv
// ---------------------------------------------------------------------------
// obi_burst_master
// Turns one command (read/write, start address, word count) into a burst of
// single-word OBI transactions, keeping up to MAX_OUTST granted requests in
// flight while their responses come back.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o      command handshake (ready only when idle)
//   cmd_we_i/cmd_addr_i/cmd_len_i  burst direction, byte start address, words
//   wr_valid_i/wr_data_i/wr_ready_o  write-data stream (one word per grant)
//   rd_valid_o/rd_data_o         read-data stream, no backpressure
//   obi                          OBI master port (interface)
//   busy_o, done_o, err_o        status: busy level, done pulse, error at done
// ---------------------------------------------------------------------------
module obi_burst_master
    import obi_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter int LEN_W     = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [31:0]               cmd_addr_i,
    input  logic [LEN_W-1:0]          cmd_len_i,
    input  logic                      wr_valid_i,
    input  logic [31:0]               wr_data_i,
    output logic                      wr_ready_o,
    output logic                      rd_valid_o,
    output logic [31:0]               rd_data_o,
    obi_burst_master_if.master        obi,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam logic [OUTST_W-1:0] MAX_OUTST_C = OUTST_W'(MAX_OUTST);

    obi_state_e         state_q, state_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   issued_q, issued_d;
    logic [OUTST_W-1:0] outst_q, outst_d;
    logic               err_q, err_d;
    logic               rd_valid_q, rd_valid_d;
    logic [31:0]        rd_data_q, rd_data_d;

    logic               req;
    logic               fire;
    logic               resp;
    obi_req_t           req_fields;

    // A request only goes out while words remain and there is room in flight.
    // Once raised it stays up until granted: issued/addr only move on a grant,
    // outstanding can only fall meanwhile, and the write stream holds its
    // valid/data until wr_ready_o.
    assign req  = (state_q == ST_ISSUE) && (issued_q != len_q) &&
                  (outst_q < MAX_OUTST_C) && (!we_q || wr_valid_i);
    assign fire = req && obi.gnt;

    // Responses with nothing in flight (e.g. left over from an abandoned
    // burst) are dropped here so they cannot underflow the counter.
    assign resp = obi.rvalid && (outst_q != '0);

    always_comb begin
        req_fields.addr  = addr_q;
        req_fields.we    = we_q;
        req_fields.be    = OBI_BE_FULL;
        req_fields.wdata = wr_data_i;
    end

    assign obi.req     = req;
    assign obi.addr    = req_fields.addr;
    assign obi.we      = req_fields.we;
    assign obi.be      = req_fields.be;
    assign obi.wdata   = req_fields.wdata;

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign wr_ready_o  = fire && we_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign busy_o      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = (state_q == ST_DONE) && err_q;

    // Next-state and datapath updates. The outstanding counter nets a grant
    // against a response in the same cycle; DRAIN looks at the post-update
    // count so a final response lets DONE follow immediately.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        outst_d    = outst_q;
        err_d      = err_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        case ({fire, resp})
            2'b10:   outst_d = outst_q + OUTST_W'(1);
            2'b01:   outst_d = outst_q - OUTST_W'(1);
            default: outst_d = outst_q;
        endcase

        if (fire) begin
            issued_d = issued_q + LEN_W'(1);
            addr_d   = addr_q + 32'd4;
        end

        if (resp) begin
            if (!we_q) begin
                rd_valid_d = 1'b1;
                rd_data_d  = obi.rdata;
            end
            if (obi.err) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    we_d     = cmd_we_i;
                    addr_d   = cmd_addr_i & 32'hFFFF_FFFC;
                    len_d    = cmd_len_i;
                    issued_d = '0;
                    err_d    = 1'b0;
                    state_d  = (cmd_len_i == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issued_d == len_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (outst_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any burst in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            outst_q    <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            outst_q    <= outst_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule
